ffe_pam4_slicer_mse: RTL and testbench

Downstream consumer of the FFE equalised output y. Runs in the data_clk domain. Per valid sample it slices the signed equaliser output into a Gray-coded PAM4 symbol and produces a signed slicer error. It also runs a start-triggered measurement FSM that accumulates squared error over a 2^LOG2_WIN sample window and reports the mean-squared error for link tuning and monitoring.

---
 rtl/ffe_pkg.sv | 33 +++
 rtl/ffe_pam4_decision.sv | 57 +++++
 rtl/ffe_pam4_slicer_mse.sv | 144 ++++++++++++++
 tb/tb_ffe_pam4_slicer_mse.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffe_pkg.sv
// ----------------------------------------------------------------------------
// ffe_pkg
// Shared definitions for the FFE slicer / MSE monitor:
//   - Gray-coded PAM4 symbol constants
//   - measurement FSM state type
//   - signed saturation range helper
// ----------------------------------------------------------------------------
package ffe_pkg;

  // Gray PAM4 mapping: adjacent levels differ in one bit
  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mse_state_t;

  // Reports whether v lies outside the w-bit two's complement range.
  // Returns {above_max, below_min}; the caller substitutes the rail value.
  function automatic logic [1:0] sat_range(input logic signed [32:0] v,
                                           input int unsigned       w);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    return {v > hi, v < lo};
  endfunction

endpackage

// File: rtl/ffe_pam4_decision.sv
// ----------------------------------------------------------------------------
// ffe_pam4_decision
// Combinational PAM4 slicer: compares y against thresholds -2L, 0, +2L,
// selects the ideal level and produces the saturated error y - ideal.
// Ports:
//   y    in  W  signed equalised sample
//   sym  out 2  Gray PAM4 symbol
//   err  out W  signed error, saturated to W bits
// ----------------------------------------------------------------------------
module ffe_pam4_decision
  import ffe_pkg::*;
#(
  parameter int unsigned W     = 12,
  parameter int unsigned LEVEL = 256
) (
  input  logic signed [W-1:0] y,
  output logic        [1:0]   sym,
  output logic signed [W-1:0] err
);

  localparam logic signed [W:0] L1 = (W+1)'(LEVEL);
  localparam logic signed [W:0] L2 = (W+1)'(2 * LEVEL);
  localparam logic signed [W:0] L3 = (W+1)'(3 * LEVEL);

  logic signed [W:0] y_ext;
  logic signed [W:0] ideal;
  logic signed [W:0] err_wide;
  logic        [1:0] flags;

  always_comb begin
    y_ext = {y[W-1], y};
    // ties resolve upward at 0 and +2L, and to -1 at exactly -2L
    if (y_ext >= L2) begin
      sym   = SYM_P3;
      ideal = L3;
    end else if (!y_ext[W]) begin
      sym   = SYM_P1;
      ideal = L1;
    end else if (y_ext >= -L2) begin
      sym   = SYM_M1;
      ideal = -L1;
    end else begin
      sym   = SYM_M3;
      ideal = -L3;
    end
    err_wide = y_ext - ideal;
    flags    = sat_range(33'(err_wide), W);
    if (flags[1]) begin
      err = {1'b0, {(W-1){1'b1}}};
    end else if (flags[0]) begin
      err = {1'b1, {(W-1){1'b0}}};
    end else begin
      err = err_wide[W-1:0];
    end
  end

endmodule

// File: rtl/ffe_pam4_slicer_mse.sv
// ----------------------------------------------------------------------------
// ffe_pam4_slicer_mse
// Slices FFE output into Gray PAM4 symbols with a registered slicer error,
// and measures mean-squared error over a 2^LOG2_WIN sample window on request.
// Ports:
//   data_clk   in   1       sample clock (rising edge)
//   rst        in   1       async reset, active-high
//   load       in   1       enable; 0 flushes outputs and aborts measurement
//   y_valid    in   1       y_in carries a new sample
//   y_in       in   W       signed equalised sample
//   start      in   1       request one MSE window (honoured in IDLE only)
//   sym_out    out  2       Gray PAM4 symbol
//   sym_valid  out  1       sym_out / err_out valid
//   err_out    out  W       signed saturated slicer error
//   busy       out  1       measurement window in progress (ACCUM or DONE)
//   mse_out    out  2W      window mean-squared error, held until next DONE
//   mse_valid  out  1       one-cycle pulse when mse_out updates
// ----------------------------------------------------------------------------
module ffe_pam4_slicer_mse
  import ffe_pkg::*;
#(
  parameter int unsigned IN_OUT_BUS_WIDTH = 12,
  parameter int unsigned LEVEL            = 256,
  parameter int unsigned LOG2_WIN         = 8
) (
  input  logic                                data_clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic                                y_valid,
  input  logic signed [IN_OUT_BUS_WIDTH-1:0]  y_in,
  input  logic                                start,
  output logic        [1:0]                   sym_out,
  output logic                                sym_valid,
  output logic signed [IN_OUT_BUS_WIDTH-1:0]  err_out,
  output logic                                busy,
  output logic        [2*IN_OUT_BUS_WIDTH-1:0] mse_out,
  output logic                                mse_valid
);

  localparam int unsigned W     = IN_OUT_BUS_WIDTH;
  localparam int unsigned ACC_W = 2 * W + LOG2_WIN;

  logic        [1:0]          dec_sym;
  logic signed [W-1:0]        dec_err;

  mse_state_t                 state;
  mse_state_t                 state_nxt;
  logic        [LOG2_WIN-1:0] cnt;
  logic        [ACC_W-1:0]    acc;
  logic        [ACC_W-1:0]    acc_sum;
  logic signed [2*W-1:0]      err_sq;
  logic                       last_sample;

  ffe_pam4_decision #(
    .W     (W),
    .LEVEL (LEVEL)
  ) u_decision (
    .y   (y_in),
    .sym (dec_sym),
    .err (dec_err)
  );

  // Output register: symbol/error hold their value while sym_valid is low
  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      sym_out   <= SYM_M3;
      sym_valid <= 1'b0;
      err_out   <= '0;
    end else begin
      sym_valid <= load & y_valid;
      if (load && y_valid) begin
        sym_out <= dec_sym;
        err_out <= dec_err;
      end
    end
  end

  always_comb begin
    // square is never negative, so the signed product reads as unsigned
    err_sq      = err_out * err_out;
    acc_sum     = acc + ACC_W'($unsigned(err_sq));
    last_sample = (state == ACCUM) && sym_valid && (cnt == '1);

    state_nxt = state;
    if (!load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = ACCUM;
        ACCUM:   if (last_sample) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator/counter; counter wraps to zero on the final sample, which
  // coincides with the DONE transition.
  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      mse_out   <= '0;
      mse_valid <= 1'b0;
    end else begin
      mse_valid <= 1'b0;
      if (!load) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              acc <= '0;
              cnt <= '0;
            end
          end
          ACCUM: begin
            if (sym_valid) begin
              acc <= acc_sum;
              cnt <= cnt + LOG2_WIN'(1);
              if (last_sample) begin
                mse_out   <= acc_sum[ACC_W-1:LOG2_WIN];
                mse_valid <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ffe_pam4_slicer_mse.sv
// ----------------------------------------------------------------------------
// tb_ffe_pam4_slicer_mse
// Self-checking bench for ffe_pam4_slicer_mse (W=12, LEVEL=256, 256-sample
// window). Reference slicing and MSE are computed from plain integer rules.
// ----------------------------------------------------------------------------
module tb_ffe_pam4_slicer_mse;

  localparam int W   = 12;
  localparam int L   = 256;
  localparam int LW  = 8;
  localparam int WIN = 256;

  logic                  data_clk = 1'b0;
  logic                  rst;
  logic                  load;
  logic                  y_valid;
  logic signed [W-1:0]   y_in;
  logic                  start;
  logic        [1:0]     sym_out;
  logic                  sym_valid;
  logic signed [W-1:0]   err_out;
  logic                  busy;
  logic        [2*W-1:0] mse_out;
  logic                  mse_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 data_clk = ~data_clk;

  ffe_pam4_slicer_mse #(
    .IN_OUT_BUS_WIDTH (W),
    .LEVEL            (L),
    .LOG2_WIN         (LW)
  ) dut (
    .data_clk  (data_clk),
    .rst       (rst),
    .load      (load),
    .y_valid   (y_valid),
    .y_in      (y_in),
    .start     (start),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .err_out   (err_out),
    .busy      (busy),
    .mse_out   (mse_out),
    .mse_valid (mse_valid)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  // Reference slicer: nearest ideal level by thresholds, then clamp error
  function automatic void ref_slice(input int y, output logic [1:0] s, output int e);
    int ideal;
    if (y >= 2 * L) begin
      s = 2'b10; ideal = 3 * L;
    end else if (y >= 0) begin
      s = 2'b11; ideal = L;
    end else if (y >= -2 * L) begin
      s = 2'b01; ideal = -L;
    end else begin
      s = 2'b00; ideal = -3 * L;
    end
    e = y - ideal;
    if (e > 2047)  e = 2047;
    if (e < -2048) e = -2048;
  endfunction

  function automatic int pick_y();
    int t;
    case ($urandom_range(0, 3))
      0: begin
        t = $urandom_range(0, 2);
        return (t - 1) * 2 * L + $urandom_range(0, 4) - 2;
      end
      1: return ($urandom_range(0, 1) != 0) ? 2047 - $urandom_range(0, 3)
                                            : -2048 + $urandom_range(0, 3);
      default: return $urandom_range(0, 4095) - 2048;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " sym_out"},   sym_out,   0);
    check({tag, " sym_valid"}, sym_valid, 0);
    check({tag, " err_out"},   err_out,   0);
    check({tag, " busy"},      busy,      0);
    check({tag, " mse_out"},   mse_out,   0);
    check({tag, " mse_valid"}, mse_valid, 0);
  endtask

  // mode: 0 const 300, 1 gapped 300, 2 alternating extremes, 3 random
  // abort_at >= 0 drops load after that many samples; exp_const < 0 skips
  // the fixed-value check.
  task automatic run_window(input int mode, input int abort_at,
                            input longint exp_const, input string tag);
    longint     sumsq   = 0;
    int         driven  = 0;
    int         last_i  = -1;
    int         pulse_i = -1;
    int         pulses  = 0;
    int         abort_i = -1;
    int         busy_bad = 0;
    int         y = 300;
    int         e;
    logic [1:0] s;
    logic       v;
    logic       exp_busy;
    load = 1'b1; y_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    for (int i = 0; i < 2000; i++) begin
      v = 1'b0;
      if (abort_at >= 0 && driven == abort_at && abort_i < 0) begin
        load = 1'b0;
        abort_i = i;
      end else if (abort_i < 0 && driven < WIN) begin
        case (mode)
          1:       v = (i % 2 == 0);
          3:       v = ($urandom_range(0, 3) != 0);
          default: v = 1'b1;
        endcase
        case (mode)
          2:       y = (driven % 2 == 0) ? 2047 : -2048;
          3:       y = pick_y();
          default: y = 300;
        endcase
      end
      y_valid = v;
      if (v) begin
        y_in = W'(y);
        ref_slice(y, s, e);
        sumsq += longint'(e) * e;
        driven++;
        if (driven == WIN) last_i = i;
      end
      start = (i == 20);  // must be ignored mid-window
      tick();
      if (mse_valid) begin
        pulses++;
        if (pulse_i < 0) pulse_i = i;
      end
      exp_busy = (abort_i < 0) && (pulse_i < 0 || i == pulse_i);
      if (busy !== exp_busy) busy_bad++;
      if (abort_i >= 0 && i >= abort_i + 8) break;
      if (pulse_i >= 0 && i >= pulse_i + 4) break;
    end
    load = 1'b1; y_valid = 1'b0; start = 1'b0;
    check({tag, " busy profile errors"}, busy_bad, 0);
    if (abort_at >= 0) begin
      check({tag, " mse_valid pulses"}, pulses, 0);
      check({tag, " mse_out held"}, mse_out, exp_const);
    end else begin
      check({tag, " mse_valid pulses"}, pulses, 1);
      check({tag, " pulse timing"}, pulse_i, last_i + 1);
      check({tag, " mse_out model"}, mse_out, sumsq / WIN);
      if (exp_const >= 0) check({tag, " mse_out const"}, mse_out, exp_const);
    end
  endtask

  typedef struct {
    int         y;
    logic [1:0] sym;
    int         err;
  } vec_t;

  initial begin
    vec_t       vecs[12];
    logic [1:0] m_sym;
    int         m_err;
    logic       exp_v;
    int         y;

    vecs[0]  = '{300,   2'b11,   44};
    vecs[1]  = '{-1000, 2'b00, -232};
    vecs[2]  = '{512,   2'b10, -256};
    vecs[3]  = '{-512,  2'b01, -256};
    vecs[4]  = '{0,     2'b11, -256};
    vecs[5]  = '{511,   2'b11,  255};
    vecs[6]  = '{2047,  2'b10, 1279};
    vecs[7]  = '{-2048, 2'b00, -1280};
    vecs[8]  = '{-511,  2'b01, -255};
    vecs[9]  = '{-513,  2'b00,  255};
    vecs[10] = '{1023,  2'b10,  255};
    vecs[11] = '{-1,    2'b01,  255};

    rst = 1'b1; load = 1'b0; y_valid = 1'b0; y_in = '0; start = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // start with load low is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start with load=0 busy", busy, 0);
    load = 1'b1;
    tick();

    foreach (vecs[i]) begin
      y_in = W'(vecs[i].y);
      y_valid = 1'b1;
      tick();
      check($sformatf("vec%0d sym_valid", i), sym_valid, 1);
      check($sformatf("vec%0d sym y=%0d", i, vecs[i].y), sym_out, vecs[i].sym);
      check($sformatf("vec%0d err y=%0d", i, vecs[i].y), err_out, vecs[i].err);
    end
    y_valid = 1'b0;
    y_in = 12'sd100;
    tick();
    check("hold sym_valid", sym_valid, 0);
    check("hold sym", sym_out, vecs[11].sym);
    check("hold err", err_out, vecs[11].err);
    m_sym = vecs[11].sym;
    m_err = vecs[11].err;

    // random slicing with random valid and load
    for (int i = 0; i < 300; i++) begin
      load = ($urandom_range(0, 7) != 0);
      y_valid = $urandom_range(0, 1);
      y = pick_y();
      y_in = W'(y);
      exp_v = load && y_valid;
      if (exp_v) ref_slice(y, m_sym, m_err);
      tick();
      check("rand sym_valid", sym_valid, exp_v);
      check("rand sym", sym_out, m_sym);
      check("rand err", err_out, m_err);
    end
    load = 1'b1; y_valid = 1'b0;
    tick();

    run_window(0, -1, 1936, "win300");

    // reset in the middle of a window
    start = 1'b1;
    tick();
    start = 1'b0;
    y_in = 12'sd300;
    y_valid = 1'b1;
    repeat (100) tick();
    #2 rst = 1'b1;
    #1 check_all_zero("reset mid-accum");
    y_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_window(0, -1, 1936, "after reset");

    run_window(1, -1, 1936, "gapped");
    run_window(0, 50, 1936, "abort");
    run_window(2, -1, 1637120, "extremes");
    run_window(3, -1, -1, "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
